// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - Shared encodings, FSM state type and counter sizing for seq_calculator.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bits needed to hold an iteration count from 0 up to width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - Iterative shift-add multiplier / restoring divider datapath.
// The divider half is compiled in only when CALC_DIV_EN is defined.
module seq_muldiv
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
`ifdef CALC_DIV_EN
    input  logic                 div_mode,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH:0]   sum;
`ifdef CALC_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
`endif

    // hi is the product high half (mul) or partial remainder (div); lo holds the
    // multiplier being shifted out (mul) or the dividend/quotient (div).
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], lo[WIDTH-1:1]};
`ifdef CALC_DIV_EN
        trial = {hi, lo[WIDTH-1]};
        diff  = trial - {1'b0, opnd};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = trial[WIDTH-1:0];
                nxt_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            count <= '0;
`ifdef CALC_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (load) begin
            hi    <= '0;
            lo    <= a;
            opnd  <= b;
            count <= CW'(WIDTH);
`ifdef CALC_DIV_EN
            div_q <= div_mode;
`endif
        end else if (step && count != '0) begin
            hi    <= nxt_hi;
            lo    <= nxt_lo;
            count <= count - CW'(1);
        end
    end

    assign last   = (count == CW'(1));
    assign result = {nxt_hi, nxt_lo};

endmodule

// File: rtl/seq_calculator.sv
// rtl/seq_calculator.sv - Multi-cycle unsigned add/sub/mul/div calculator with start/busy/done.
// Division is available only when CALC_DIV_EN is defined; otherwise OP=11 is flagged illegal.
module seq_calculator
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           OP,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out,
    output logic                 overflow,
    output logic                 div_by_zero
);

    state_t             state;
    logic               is_iter;
    logic               load;
    logic               last;
    logic [2*WIDTH-1:0] iter_result;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   sub_diff;
`ifdef CALC_DIV_EN
    logic               div_zero_q;

    assign is_iter = (OP == OP_MUL) || (OP == OP_DIV);
`else
    assign is_iter = (OP == OP_MUL);
`endif

    assign load     = start && (state != RUN) && is_iter;
    assign add_sum  = {1'b0, A} + {1'b0, B};
    assign sub_diff = A - B;

    seq_muldiv #(
        .WIDTH    (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (state == RUN),
`ifdef CALC_DIV_EN
        .div_mode (OP == OP_DIV),
`endif
        .a        (A),
        .b        (B),
        .last     (last),
        .result   (iter_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            out         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef CALC_DIV_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        if (is_iter) begin
                            busy  <= 1'b1;
                            state <= RUN;
`ifdef CALC_DIV_EN
                            div_zero_q <= (OP == OP_DIV) && (B == '0);
`endif
                        end else begin
                            done        <= 1'b1;
                            state       <= DONE;
                            div_by_zero <= 1'b0;
                            case (OP)
                                OP_ADD: begin
                                    out      <= {{(WIDTH-1){1'b0}}, add_sum};
                                    overflow <= add_sum[WIDTH];
                                end
                                OP_SUB: begin
                                    out      <= {{WIDTH{1'b0}}, sub_diff};
                                    overflow <= (A < B);
                                end
                                default: begin
                                    out      <= '0;
                                    overflow <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                RUN: begin
                    if (last) begin
                        out      <= iter_result;
                        overflow <= 1'b0;
`ifdef CALC_DIV_EN
                        div_by_zero <= div_zero_q;
`else
                        div_by_zero <= 1'b0;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// tb/tb_seq_calculator.sv - Scoreboard bench for seq_calculator at WIDTH=4 and WIDTH=8.
module tb_seq_calculator;

    typedef struct {
        logic [15:0] out;
        logic        ovf;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start4 = 1'b0, start8 = 1'b0;
    logic [1:0]  op4 = 2'b00, op8 = 2'b00;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy4, done4, ovf4, dz4;
    logic        busy8, done8, ovf8, dz8;
    logic [7:0]  out4;
    logic [15:0] out8;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    seq_calculator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .OP(op4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .out(out4), .overflow(ovf4), .div_by_zero(dz4)
    );

    seq_calculator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .OP(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .out(out8), .overflow(ovf8), .div_by_zero(dz8)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int w, input int op, input int a, input int b);
        exp_t e;
        int   mask;
        mask  = (1 << w) - 1;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        case (op)
            0: begin e.out = 16'(a + b); e.ovf = ((a + b) >> w) != 0; end
            1: begin e.out = 16'((a - b) & mask); e.ovf = (a < b); end
            2: e.out = 16'(a * b);
`ifdef CALC_DIV_EN
            default: begin
                if (b == 0) begin e.out = 16'((a << w) | mask); e.dz = 1'b1; end
                else e.out = 16'(((a % b) << w) | (a / b));
            end
`else
            default: begin e.out = 16'h0; e.ovf = 1'b1; end
`endif
        endcase
        return e;
    endfunction

    function automatic logic [15:0] cur_out(input bit w8);
        return w8 ? out8 : {8'h00, out4};
    endfunction

    task automatic check_pop(input bit w8, input string name);
        exp_t e;
        logic [15:0] o;
        logic ov, dz;
        o  = cur_out(w8);
        ov = w8 ? ovf8 : ovf4;
        dz = w8 ? dz8 : dz4;
        if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s scoreboard: done with empty queue", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (o !== e.out) begin errors++; $display("FAIL %s out: got %h expected %h", name, o, e.out); end
        checks++;
        if (ov !== e.ovf) begin errors++; $display("FAIL %s overflow: got %b expected %b", name, ov, e.ovf); end
        checks++;
        if (dz !== e.dz) begin errors++; $display("FAIL %s div_by_zero: got %b expected %b", name, dz, e.dz); end
    endtask

    task automatic run_op(input bit w8, input int op, input int a, input int b,
                          input bit poke, input string name);
        int  w, n, busy_cnt, exp_lat;
        bit  got, iter;
        w = w8 ? 8 : 4;
`ifdef CALC_DIV_EN
        iter = (op >= 2);
`else
        iter = (op == 2);
`endif
        exp_lat = iter ? w + 1 : 1;
        exp_q.push_back(model(w, op, a, b));
        @(posedge clk); #1;
        if (w8) begin start8 = 1'b1; op8 = 2'(op); a8 = 8'(a); b8 = 8'(b); end
        else    begin start4 = 1'b1; op4 = 2'(op); a4 = 4'(a); b4 = 4'(b); end
        @(posedge clk); #1;
        start4 = 1'b0; start8 = 1'b0;
        n = 0; busy_cnt = 0; got = 0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (poke && n == 2) begin start4 = 1'b1; op4 = 2'b00; a4 = 4'd1; b4 = 4'd1; end
            if (poke && n == 3) start4 = 1'b0;
            if (w8 ? busy8 : busy4) busy_cnt++;
            if (w8 ? done8 : done4) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, n);
            void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (n != exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat); end
        checks++;
        if (busy_cnt != (iter ? w : 0)) begin
            errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, iter ? w : 0);
        end
        check_pop(w8, name);
        @(negedge clk);
        checks++;
        if ((w8 ? done8 : done4) !== 1'b0) begin errors++; $display("FAIL %s done pulse width: done still high", name); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy4, done4, out4, ovf4, dz4} !== '0) begin
            errors++; $display("FAIL reset4: got %b expected all zero", {busy4, done4, out4, ovf4, dz4});
        end
        checks++;
        if ({busy8, done8, out8, ovf8, dz8} !== '0) begin
            errors++; $display("FAIL reset8: got %b expected all zero", {busy8, done8, out8, ovf8, dz8});
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        run_op(0, 0, 15, 1, 0, "add_15_1");
        run_op(0, 0, 3, 4, 0, "add_3_4");
        run_op(0, 1, 3, 5, 0, "sub_3_5");
        run_op(0, 1, 9, 4, 0, "sub_9_4");
    endtask

    task automatic test_mul();
        run_op(0, 2, 15, 15, 1, "mul_15_15_poke");
        run_op(0, 2, 5, 3, 0, "mul_5_3");
        // No completion should follow the ignored start.
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (done4 !== 1'b0) begin errors++; $display("FAIL mul_ignored_start: got done=1 expected 0"); end
        end
        checks++;
        if (out4 !== 8'h0F) begin errors++; $display("FAIL mul_hold: got %h expected 0f", out4); end
    endtask

    task automatic test_div_or_illegal();
        run_op(0, 3, 13, 4, 0, "div_13_4");
        run_op(0, 3, 9, 0, 0, "div_9_0");
        run_op(0, 3, 15, 15, 0, "div_15_15");
        run_op(1, 3, 200, 7, 0, "div8_200_7");
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(model(4, 0, 1, 2));
        @(posedge clk); #1;
        start4 = 1'b1; op4 = 2'b00; a4 = 4'd1; b4 = 4'd2;
        @(posedge clk); #1;
        exp_q.push_back(model(4, 1, 9, 4));
        op4 = 2'b01; a4 = 4'd9; b4 = 4'd4;
        @(negedge clk);
        checks++;
        if (done4 !== 1'b1) begin errors++; $display("FAIL b2b_add done: got %b expected 1", done4); end
        check_pop(0, "b2b_add");
        @(posedge clk); #1;
        exp_q.push_back(model(4, 2, 3, 5));
        op4 = 2'b10; a4 = 4'd3; b4 = 4'd5;
        @(negedge clk);
        checks++;
        if (done4 !== 1'b1) begin errors++; $display("FAIL b2b_sub done: got %b expected 1", done4); end
        check_pop(0, "b2b_sub");
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done4 !== 1'b0) begin errors++; $display("FAIL b2b_mul early done: got 1 expected 0"); end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b1) begin errors++; $display("FAIL b2b_mul done: got %b expected 1", done4); end
        check_pop(0, "b2b_mul");
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(posedge clk); #1;
        start4 = 1'b1; op4 = 2'b10; a4 = 4'd7; b4 = 4'd6;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy4, done4, out4, ovf4, dz4} !== '0) begin
            errors++; $display("FAIL reset_mid_run: got %b expected all zero", {busy4, done4, out4, ovf4, dz4});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_abort: got %0d active cycles expected 0", seen); end
        run_op(0, 2, 7, 6, 0, "mul_7_6_after_reset");
    endtask

    task automatic test_width8();
        run_op(1, 2, 255, 255, 0, "mul8_255_255");
        run_op(1, 0, 200, 100, 0, "add8_200_100");
        run_op(1, 1, 10, 20, 0, "sub8_10_20");
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div_or_illegal();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard drain: %0d left expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_calculator.md
# seq_calculator

Parametrised, multi-cycle unsigned calculator and the clocked successor to the combinational 4-bit calculator. It adds, subtracts, multiplies and optionally divides two WIDTH-bit operands behind a start/busy/done handshake. Add/sub finish in one cycle; mul/div use a shared iterative shift datapath taking WIDTH cycles. It sits between operand-entry logic (switches/registers) and the display/output formatting stage.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..16
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when busy=0
- OP  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- A  in  WIDTH  operand A, unsigned
- B  in  WIDTH  operand B, unsigned
- busy  out  1  high while a mul/div iteration is in progress
- done  out  1  one-cycle pulse when out/flags are updated
- out  out  2*WIDTH  result, held until next completion
- overflow  out  1  carry (add), borrow (sub), illegal op; else 0
- div_by_zero  out  1  set on div with B=0; else 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture OP/A/B.
  - Add/sub: register result at the same edge, go to DONE.
  - Mul/div: load counter=WIDTH, go to RUN.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge; counter decrements. At count 1, register result and go to DONE.
- DONE: done=1 for this cycle only; return to IDLE. busy=0 in DONE, so start is accepted here with the same rules as IDLE.
- start while busy=1 is ignored; operands are not re-sampled.
- Add: out = zero-extended (WIDTH+1)-bit A+B; overflow = carry.
- Sub: out = zero-extended WIDTH-bit (A-B) mod 2^WIDTH; overflow = (A<B).
- Mul: out = full 2*WIDTH product; overflow=0.
- Div: out = {remainder, quotient}, each WIDTH bits.
  - B=0: quotient all-ones, remainder=A, div_by_zero=1, completion takes the normal WIDTH cycles.
- Flags are updated only at completion, together with out.

## Timing
- Reset: state IDLE; busy, done, out, overflow and div_by_zero all 0; counter 0.
- Reset asserted mid-RUN aborts the operation; no done pulse follows.
- Add/sub: start sampled at edge k; done is high in the cycle after edge k. Latency 1.
- Mul/div: start sampled at edge k; busy is high between edges k and k+WIDTH. Result is registered at edge k+WIDTH, and done is high for the following cycle. Latency WIDTH.
- Back-to-back: a start accepted in the DONE cycle gives the next done 1 or WIDTH edges later. There are no dead cycles.

## Configuration
- CALC_DIV_EN defined: OP=11 performs division as above.
- CALC_DIV_EN undefined:
  - Divider logic is not compiled in.
  - OP=11 is illegal: 1-cycle latency, out=0, overflow=1, div_by_zero=0.

## Structure
- Package calc_pkg holds:
  - OP encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - the FSM state typedef
  - the counter-width function clog2(WIDTH+1)
- Sub-module seq_muldiv contains the iterative datapath: accumulator/remainder register, operand shift register and counter.
  - It has a load/step interface; the top level owns the FSM, add/sub logic and output registers.

## Test plan
- WIDTH=4, add 15+1 -> done one cycle after start, out=0x10, overflow=1.
- Sub 3-5 -> out=0x0E, overflow=1. Sub 9-4 -> out=0x05, overflow=0.
- Mul 15*15 -> busy high exactly 4 cycles, then done, out=0xE1. A second start during busy is ignored.
- Div 13/4 -> out=0x13 after 4 cycles. Div 9/0 -> out=0x9F, div_by_zero=1.
- Reset asserted two cycles into mul 7*6 -> all outputs 0 and no done. A fresh 7*6 afterwards gives out=0x2A.
- WIDTH=8, mul 255*255 -> out=0xFE01 after 8 cycles. Build without CALC_DIV_EN, OP=11 -> out=0, overflow=1, latency 1.
